// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath per opcode,
// stalls on the memory handshake and counts retired instructions.
module multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       instruction,
  input  logic [5:0]       instruction_2,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       AluControl,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic       w_ready;
  logic       w_is_r;
  logic       w_is_mem;
  logic       w_is_lw;
  logic       w_is_beq;
  logic       w_is_j;
  logic       w_is_addi;
  logic       w_fn_ok;
  logic       w_illegal;
  logic       w_retire;
  logic [3:0] w_alu_fn;

  assign w_ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign w_is_r    = (instruction == OP_R);
  assign w_is_lw   = (instruction == OP_LW);
  assign w_is_mem  = w_is_lw || (instruction == OP_SW);
  assign w_is_beq  = (instruction == OP_BEQ);
  assign w_is_j    = (instruction == OP_J);
  assign w_is_addi = (instruction == OP_ADDI);

  always_comb begin
    w_fn_ok  = 1'b1;
    w_alu_fn = ALU_ADD;
    case (instruction_2)
      FN_ADD:  w_alu_fn = ALU_ADD;
      FN_SUB:  w_alu_fn = ALU_SUB;
      FN_AND:  w_alu_fn = ALU_AND;
      FN_OR:   w_alu_fn = ALU_OR;
      FN_SLT:  w_alu_fn = ALU_SLT;
      default: w_fn_ok  = 1'b0;
    endcase
  end

  assign w_illegal = !((w_is_r && w_fn_ok) || w_is_mem || w_is_beq
                       || w_is_j || w_is_addi);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          w_is_r && w_fn_ok: w_next = S_EXEC;
          w_is_mem:          w_next = S_MEMADR;
          w_is_beq:          w_next = S_BRANCH;
          w_is_j:            w_next = S_JUMP;
          w_is_addi:         w_next = S_ADDIEX;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = w_is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Retire on the last cycle of an instruction; illegal ops never get here
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB)
                 || (r_state == S_ADDIWB) || (r_state == S_BRANCH)
                 || (r_state == S_JUMP)
                 || ((r_state == S_MEMWR) && w_ready);

  always_ff @(posedge clk) begin
    if (reset)         r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign instr_count = r_cnt;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    AluControl  = 4'b0000;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    if (reset) begin
      AluControl = ALU_ADD;
    end else begin
      case (r_state)
        S_FETCH: begin
          MemRead    = 1'b1;
          ALUSrcB    = 2'b01;
          AluControl = ALU_ADD;
          IRWrite    = w_ready;
          PCWrite    = w_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          AluControl = ALU_ADD;
          illegal_op = w_illegal;
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          AluControl = ALU_ADD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA    = 1'b1;
          AluControl = w_alu_fn;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          AluControl  = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = zero;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction stream and handshake
// against a per-instruction step-list model of the control sequence.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  instruction;
  logic [5:0]  instruction_2;
  logic        zero;
  logic        mem_ready;
  wire  [18:0] ctl;
  wire  [18:0] ctl3;
  wire  [31:0] instr_count;
  wire  [2:0]  instr_count3;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] alu;
    logic [1:0] pcs;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    ctl_t busy;
    ctl_t rdy;
    logic waits;
    logic term;
  } step_t;

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .instruction(instruction), .instruction_2(instruction_2),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(ctl[18]), .PCWriteCond(ctl[17]), .IorD(ctl[16]),
    .MemRead(ctl[15]), .MemWrite(ctl[14]), .IRWrite(ctl[13]),
    .MemtoReg(ctl[12]), .RegDst(ctl[11]), .RegWrite(ctl[10]),
    .ALUSrcA(ctl[9]), .ALUSrcB(ctl[8:7]), .AluControl(ctl[6:3]),
    .PCSource(ctl[2:1]), .illegal_op(ctl[0]),
    .instr_count(instr_count)
  );

  // Narrow counter copy exercises the wrap from all-ones to zero
  multicycle_control #(.MEM_HANDSHAKE(1'b1), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset),
    .instruction(instruction), .instruction_2(instruction_2),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(ctl3[18]), .PCWriteCond(ctl3[17]), .IorD(ctl3[16]),
    .MemRead(ctl3[15]), .MemWrite(ctl3[14]), .IRWrite(ctl3[13]),
    .MemtoReg(ctl3[12]), .RegDst(ctl3[11]), .RegWrite(ctl3[10]),
    .ALUSrcA(ctl3[9]), .ALUSrcB(ctl3[8:7]), .AluControl(ctl3[6:3]),
    .PCSource(ctl3[2:1]), .illegal_op(ctl3[0]),
    .instr_count(instr_count3)
  );

  always #5 clk = ~clk;

  step_t       q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input ctl_t c, input logic w,
                               input logic t);
    step_t s;
    s.busy  = c;
    s.rdy   = c;
    s.waits = w;
    s.term  = t;
    q.push_back(s);
  endfunction

  function automatic void build(input logic [31:0] ir);
    logic [5:0] op = ir[31:26];
    logic [5:0] fn = ir[5:0];
    logic [3:0] alu = 4'b0010;
    logic       r_ok = 1'b1;
    ctl_t       c;
    step_t      s;
    q.delete();
    c = '0; c.mrd = 1; c.srcb = 2'b01; c.alu = 4'b0010;
    s.busy = c;
    c.irw = 1; c.pcw = 1;
    s.rdy = c; s.waits = 1; s.term = 0;
    q.push_back(s);
    case (fn)
      6'b100000: alu = 4'b0010;
      6'b100010: alu = 4'b0110;
      6'b100100: alu = 4'b0000;
      6'b100101: alu = 4'b0001;
      6'b101010: alu = 4'b0111;
      default:   r_ok = 1'b0;
    endcase
    c = '0; c.srcb = 2'b11; c.alu = 4'b0010;
    case (op)
      6'b000000: begin
        c.ill = !r_ok;
        push(c, 0, 0);
        if (r_ok) begin
          c = '0; c.srca = 1; c.alu = alu; push(c, 0, 0);
          c = '0; c.rw = 1; c.rdst = 1; push(c, 0, 1);
        end
      end
      6'b100011, 6'b101011: begin
        push(c, 0, 0);
        c = '0; c.srca = 1; c.srcb = 2'b10; c.alu = 4'b0010;
        push(c, 0, 0);
        if (op == 6'b100011) begin
          c = '0; c.mrd = 1; c.iord = 1; push(c, 1, 0);
          c = '0; c.rw = 1; c.m2r = 1; push(c, 0, 1);
        end else begin
          c = '0; c.mwr = 1; c.iord = 1; push(c, 1, 1);
        end
      end
      6'b000100: begin
        push(c, 0, 0);
        c = '0; c.srca = 1; c.alu = 4'b0110; c.pcwc = 1; c.pcs = 2'b01;
        push(c, 0, 1);
      end
      6'b000010: begin
        push(c, 0, 0);
        c = '0; c.pcw = 1; c.pcs = 2'b10; push(c, 0, 1);
      end
      6'b001000: begin
        push(c, 0, 0);
        c = '0; c.srca = 1; c.srcb = 2'b10; c.alu = 4'b0010;
        push(c, 0, 0);
        c = '0; c.rw = 1; push(c, 0, 1);
      end
      default: begin
        c.ill = 1;
        push(c, 0, 0);
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] ir = $urandom;
    logic [5:0]  op;
    int          k = $urandom_range(0, 11);
    case (k)
      0: begin ir[31:26] = 6'b000000; ir[5:0] = 6'b100000; end
      1: begin ir[31:26] = 6'b000000; ir[5:0] = 6'b100010; end
      2: begin ir[31:26] = 6'b000000; ir[5:0] = 6'b100100; end
      3: begin ir[31:26] = 6'b000000; ir[5:0] = 6'b100101; end
      4: begin ir[31:26] = 6'b000000; ir[5:0] = 6'b101010; end
      5: ir[31:26] = 6'b100011;
      6: ir[31:26] = 6'b101011;
      7: ir[31:26] = 6'b000100;
      8: ir[31:26] = 6'b000010;
      9: ir[31:26] = 6'b001000;
      10: begin
        op = 6'($urandom);
        while (op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b000010, 6'b001000})
          op = 6'($urandom);
        ir[31:26] = op;
      end
      default: begin
        ir[31:26] = 6'b000000;
        while (ir[5:0] inside {6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010})
          ir[5:0] = 6'($urandom);
      end
    endcase
    return ir;
  endfunction

  logic [31:0] dir[7] = '{32'h00441020, 32'h11000003, 32'h8C430004,
                          32'hAC430004, 32'h08000010, 32'hFC000000,
                          32'hAC430008};

  initial begin
    logic [31:0] ir = 32'h0;
    int          ndir = 0;
    int          stall = 0;
    bit          did_rst = 0;
    bit          rst;
    ctl_t        exp;
    ctl_t        rst_vec;
    rst_vec = '0;
    rst_vec.alu = 4'b0010;
    reset = 1; instruction = 0; instruction_2 = 0;
    zero = 0; mem_ready = 0;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
      if (!did_rst && ndir >= 7 && q.size() > 0 && q[0].busy.mwr) begin
        rst = 1;
        did_rst = 1;
      end
      if (!rst && q.size() == 0) begin
        if (ndir < 7) begin
          ir = dir[ndir];
          ndir++;
          if (ndir == 3) stall = 2;
        end else begin
          ir = rand_ir();
        end
        build(ir);
      end
      reset = rst;
      instruction = ir[31:26];
      instruction_2 = ir[5:0];
      zero = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      if (!rst && stall > 0 && q[0].busy.mrd && q[0].busy.iord) begin
        mem_ready = 0;
        stall--;
      end
      @(negedge clk);
      if (rst) exp = rst_vec;
      else     exp = mem_ready ? q[0].rdy : q[0].busy;
      chk("ctl", 32'(ctl), 32'(exp));
      chk("ctl_w3", 32'(ctl3), 32'(exp));
      chk("count", instr_count, m_cnt);
      chk("count_w3", 32'(instr_count3), 32'(m_cnt[2:0]));
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_cnt = 0;
      end else if (!q[0].waits || mem_ready) begin
        if (q[0].term) m_cnt++;
        void'(q.pop_front());
      end
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
